pmi_clkgen_multi: RTL
=====================

# pmi_clkgen_multi

Synthesizable, multi-channel clock-enable and divided-clock generator in CLKI's domain, run-time reconfigurable. It succeeds the behavioural PLL model for designs that need divided, phase-offset, duty-programmable clocks without a hard PLL. Per channel it provides an integer divider, a phase offset and a high-time count. A global align/lock state machine keeps all channels phase-coherent and drives LOCK.

## Interface
- NUM_CH, 4: number of output channels (1..16)
- DIV_W, 8: width of divider, high-time and phase fields
- DIV_INIT, 2: reset divider for all channels
- HIGH_INIT, 1: reset high-time for all channels
- LOCK_CYCLES, 16: cycles from align to LOCK assertion (≥1)
- CLKI  in  1  the single clock; all logic on rising edge
- RESETN  in  1  reset, synchronous, active-low
- CFG_WE  in  1  config write strobe, one cycle
- CFG_CH  in  max(1,$clog2(NUM_CH))  target channel
- CFG_DIV  in  DIV_W  divider value
- CFG_HIGH  in  DIV_W  high-time in CLKI cycles
- CFG_PHASE  in  DIV_W  phase offset in CLKI cycles
- CFG_ACK  out  1  one-cycle pulse, write accepted
- CFG_ERR  out  1  one-cycle pulse, write rejected
- ALIGN  in  1  resynchronise all channels, no config change
- CH_EN  in  NUM_CH  per-channel output enable
- CLKO  out  NUM_CH  divided clock outputs, registered
- CLKO_CE  out  NUM_CH  one-cycle enable at each CLKO period start, registered
- LOCK  out  1  all channels aligned and stable

## Operation
- Per-channel shadow registers: div, high, phase. Reset values: DIV_INIT, HIGH_INIT, 0.
- Per-channel counter cnt runs 0..div-1 and wraps to 0.
- At align, cnt loads (div - phase) mod div. PHASE=0 gives cnt=0 in the first run cycle; PHASE=p delays the first wrap by p cycles.
- CLKO[i] = CH_EN[i] & (cnt < high).
- CLKO_CE[i] = CH_EN[i] & (cnt == 0).
- Special cases:
  - high ≥ div: CLKO constant 1.
  - high = 0: CLKO constant 0.
  - div = 0: counter held at 0, CLKO=0, CLKO_CE=0.
  - div = 1: CLKO_CE=1 every cycle.
- CH_EN gates outputs only. Counters keep running, so re-enabling preserves phase.
- Config write handling:
  - Rejected if CFG_PHASE ≥ CFG_DIV with CFG_DIV ≠ 0, or CFG_CH ≥ NUM_CH. Rejection gives a CFG_ERR pulse, no state change, and LOCK unaffected.
  - Accepted: shadow updated, CFG_ACK pulse, FSM forced to ALIGN_S.
- Global FSM states RST_S, ALIGN_S, WAIT_S, LOCKED_S:
  - RST_S: entered whenever RESETN=0 at an edge; goes to ALIGN_S at the first edge with RESETN=1.
  - ALIGN_S: one cycle; all counters load their start values and lock_cnt ← 0; then WAIT_S.
  - WAIT_S: counters run and lock_cnt increments; at lock_cnt = LOCK_CYCLES-1, go to LOCKED_S.
  - LOCKED_S: LOCK=1.
  - An accepted write or ALIGN=1 in WAIT_S or LOCKED_S goes to ALIGN_S. This is the highest priority after reset.
- Simultaneous ALIGN and CFG_WE: the write is evaluated first and one align results. A rejected write with ALIGN still aligns.

## Timing
- Reset values, registered at the first edge with RESETN=0: CLKO=0, CLKO_CE=0, LOCK=0, CFG_ACK=0, CFG_ERR=0. Counters 0; shadows at init values.
- Reset mid-operation: all outputs 0 at the next edge regardless of state. Pending writes are discarded.
- CFG_ACK/CFG_ERR: pulse in the cycle after CFG_WE is sampled.
- LOCK timing:
  - LOCK falls in the cycle after the write or ALIGN is sampled.
  - LOCK rises LOCK_CYCLES+1 cycles after the ALIGN_S cycle.
- Output timing:
  - CLKO and CLKO_CE are registered and lag the counter by one cycle.
  - For PHASE=0, the first CLKO_CE is high in the second cycle after ALIGN_S.
- Channel outputs run during WAIT_S, so they are valid before LOCK.
- Back-to-back writes on consecutive cycles are each accepted and each restarts the align.

## Structure
- Shared package pmi_clkgen_pkg holds:
  - the FSM state enum (RST_S, ALIGN_S, WAIT_S, LOCKED_S);
  - the channel config struct {div, high, phase};
  - the DIV_W-based width constants;
  - a start-value function (div - phase) mod div.
- One sub-module: pmi_clkgen_ch. It holds one channel's shadow registers, counter and output registers. It is instantiated NUM_CH times via generate.
- The top level holds the FSM, lock counter, write decode and validation.

## Test plan
- Reset release, channel 0 at DIV=4, HIGH=2, PHASE=0, CH_EN=1 -> CLKO pattern 1,1,0,0 repeating; CLKO_CE every 4th cycle; LOCK=1 exactly 17 cycles after ALIGN_S.
- Ch0 DIV=4/PHASE=0 and ch1 DIV=4/PHASE=1 -> ch1 CLKO_CE always exactly 1 cycle after ch0's.
- Ch2 write DIV=3, PHASE=3 -> CFG_ERR pulse, no CFG_ACK, LOCK stays 1, ch2 output unchanged.
- Ch3 HIGH=5 with DIV=4 -> CLKO[3] constant 1; then DIV=0 -> CLKO[3] and CLKO_CE[3] constant 0.
- Valid write while LOCKED -> CFG_ACK next cycle, LOCK low next cycle, all channels realigned, LOCK back after 17 cycles.
- RESETN low for one cycle mid-run, with CH_EN toggled before it -> all outputs 0 at the next edge; after release, phase relation matches the PHASE settings.

Source files
------------

// File: rtl/pmi_clkgen_pkg.sv
// Shared types for the multi-channel clock generator: FSM states, channel
// config record and the counter start-value helper.
package pmi_clkgen_pkg;

  // Internal config field width; DIV_W-wide port values are zero-extended into it
  localparam int CFG_W = 16;

  typedef logic [CFG_W-1:0] cval_t;

  typedef enum logic [1:0] {RST_S, ALIGN_S, WAIT_S, LOCKED_S} fsm_e;

  typedef struct packed {
    cval_t div;
    cval_t high;
    cval_t phase;
  } ch_cfg_t;

  // (div - phase) mod div, relying on the write check keeping phase < div
  function automatic cval_t start_val(cval_t div, cval_t phase);
    if (div == '0 || phase == '0 || phase >= div) return '0;
    return div - phase;
  endfunction

endpackage

// File: rtl/pmi_clkgen_multi_if.sv
// Configuration write port of pmi_clkgen_multi: request fields plus ack/err pulses.
interface pmi_clkgen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             CFG_WE;
  logic [CH_W-1:0]  CFG_CH;
  logic [DIV_W-1:0] CFG_DIV;
  logic [DIV_W-1:0] CFG_HIGH;
  logic [DIV_W-1:0] CFG_PHASE;
  logic             CFG_ACK;
  logic             CFG_ERR;

  modport master (output CFG_WE, CFG_CH, CFG_DIV, CFG_HIGH, CFG_PHASE,
                  input  CFG_ACK, CFG_ERR);
  modport slave  (input  CFG_WE, CFG_CH, CFG_DIV, CFG_HIGH, CFG_PHASE,
                  output CFG_ACK, CFG_ERR);
endinterface

// File: rtl/pmi_clkgen_multi_ch.sv
// One output channel: shadow config, free-running period counter and
// registered CLKO / CLKO_CE.
module pmi_clkgen_ch
  import pmi_clkgen_pkg::*;
#(
  parameter int DIV_INIT  = 2,
  parameter int HIGH_INIT = 1
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    wr,
  input  ch_cfg_t cfg_in,
  input  logic    load,
  input  logic    run,
  input  logic    en,
  output logic    clko,
  output logic    clko_ce
);

  ch_cfg_t sh;
  cval_t   cnt;
  logic    wrap;

  assign wrap = (sh.div == '0) || (cnt >= sh.div - cval_t'(1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh      <= '{div: CFG_W'(DIV_INIT), high: CFG_W'(HIGH_INIT), phase: '0};
      cnt     <= '0;
      clko    <= 1'b0;
      clko_ce <= 1'b0;
    end else begin
      if (wr) sh <= cfg_in;
      if (load)     cnt <= start_val(sh.div, sh.phase);
      else if (run) cnt <= wrap ? '0 : cnt + cval_t'(1);
      // Outputs only follow the counter while it runs; held low during align
      clko    <= run && en && (sh.div != '0) && (cnt < sh.high);
      clko_ce <= run && en && (sh.div != '0) && (cnt == '0);
    end
  end

endmodule

// File: rtl/pmi_clkgen_multi.sv
// Multi-channel divided clock / clock-enable generator: config write check,
// global align/lock FSM and NUM_CH channel instances.
module pmi_clkgen_multi
  import pmi_clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DIV_INIT    = 2,
  parameter int HIGH_INIT   = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                CLKI,
  input  logic                RESETN,
  pmi_clkgen_multi_if.slave   cfg,
  input  logic                ALIGN,
  input  logic [NUM_CH-1:0]   CH_EN,
  output logic [NUM_CH-1:0]   CLKO,
  output logic [NUM_CH-1:0]   CLKO_CE,
  output logic                LOCK
);

  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  fsm_e            state, state_nxt;
  logic [LC_W-1:0] lock_cnt;
  logic            ack_q, err_q;
  logic            ch_ok, phase_ok, wr_ok, wr_bad;
  logic            load, run;
  ch_cfg_t         wcfg;

  assign ch_ok    = 32'(cfg.CFG_CH) < NUM_CH;
  assign phase_ok = (cfg.CFG_DIV == '0) || (cfg.CFG_PHASE < cfg.CFG_DIV);
  assign wr_ok    = cfg.CFG_WE && ch_ok && phase_ok;
  assign wr_bad   = cfg.CFG_WE && !wr_ok;

  assign wcfg = '{div:   CFG_W'(cfg.CFG_DIV),
                  high:  CFG_W'(cfg.CFG_HIGH),
                  phase: CFG_W'(cfg.CFG_PHASE)};

  always_ff @(posedge CLKI) begin
    if (!RESETN) begin
      state    <= RST_S;
      lock_cnt <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= wr_ok;
      err_q <= wr_bad;
      if (state == ALIGN_S)     lock_cnt <= '0;
      else if (state == WAIT_S) lock_cnt <= lock_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST_S:    state_nxt = ALIGN_S;
      ALIGN_S:  state_nxt = WAIT_S;
      WAIT_S:   if (lock_cnt == LC_W'(LOCK_CYCLES - 1)) state_nxt = LOCKED_S;
      LOCKED_S: state_nxt = LOCKED_S;
      default:  state_nxt = RST_S;
    endcase
    // Any accepted write or explicit ALIGN restarts the whole alignment
    if (state != RST_S && (wr_ok || ALIGN)) state_nxt = ALIGN_S;
  end

  assign load        = (state == ALIGN_S);
  assign run         = (state == WAIT_S) || (state == LOCKED_S);
  assign LOCK        = (state == LOCKED_S);
  assign cfg.CFG_ACK = ack_q;
  assign cfg.CFG_ERR = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pmi_clkgen_ch #(
      .DIV_INIT  (DIV_INIT),
      .HIGH_INIT (HIGH_INIT)
    ) u_ch (
      .clk     (CLKI),
      .rstn    (RESETN),
      .wr      (wr_ok && (32'(cfg.CFG_CH) == 32'(i))),
      .cfg_in  (wcfg),
      .load    (load),
      .run     (run),
      .en      (CH_EN[i]),
      .clko    (CLKO[i]),
      .clko_ce (CLKO_CE[i])
    );
  end

endmodule
